// File: rtl/dataint_ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks DEPTH words, corrects single-bit errors in place, counts CE/UE.
// Latency: INTERVAL idle cycles plus one RAM read per step; a write-back follows only on a correctable error.
// Backpressure: req/addr/we/wdata are held until gnt; rvalid may arrive any time after issue. ECC_SCRUB_ERRLOG_EN adds last-error address outputs.
module dataint_ecc_scrub_ctrl #(
  parameter  int WIDTH      = 32,
  parameter  int ADDR_WIDTH = 10,
  parameter  int DEPTH      = 1024,
  parameter  int INTERVAL   = 256,
  localparam int CW         = WIDTH + $clog2(WIDTH + $clog2(WIDTH) + 1) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [CW-1:0]         o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [CW-1:0]         i_mem_rdata,
  output logic [CW-1:0]         o_dec_codeword,
  input  logic [WIDTH-1:0]      i_dec_data,
  input  logic                  i_dec_err,
  input  logic                  i_dec_dbl,
  output logic [WIDTH-1:0]      o_enc_data,
  input  logic [CW-1:0]         i_enc_codeword,
  output logic                  o_busy,
  output logic                  o_pass_done,
  output logic [15:0]           o_ce_count,
  output logic [15:0]           o_ue_count
`ifdef ECC_SCRUB_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] o_last_ce_addr,
  output logic [ADDR_WIDTH-1:0] o_last_ue_addr
`endif
);

  localparam int                    ICW       = $clog2(INTERVAL + 1);
  localparam logic [ICW-1:0]        ILAST     = ICW'(INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] ALAST     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_RDW,
    S_CHK,
    S_ENC,
    S_WR,
    S_NXT
  } state_t;

  state_t         state;
  logic [ICW-1:0] icnt;

  // o_mem_addr doubles as the scrub pointer, so it survives disable/enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      icnt           <= '0;
      o_mem_req      <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_dec_codeword <= '0;
      o_enc_data     <= '0;
      o_busy         <= 1'b0;
      o_pass_done    <= 1'b0;
      o_ce_count     <= '0;
      o_ue_count     <= '0;
`ifdef ECC_SCRUB_ERRLOG_EN
      o_last_ce_addr <= '0;
      o_last_ue_addr <= '0;
`endif
    end else begin
      o_pass_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_enable) state <= S_WAIT;
        end

        S_WAIT: begin
          if (!i_enable) begin
            icnt  <= '0;
            state <= S_IDLE;
          end else if (icnt == ILAST) begin
            icnt      <= '0;
            o_mem_req <= 1'b1;
            o_mem_we  <= 1'b0;
            o_busy    <= 1'b1;
            state     <= S_RD;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end

        S_RD: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            state     <= S_RDW;
          end
        end

        // Late enable drops are honoured only after the step finishes.
        S_RDW: begin
          if (i_mem_rvalid) begin
            o_dec_codeword <= i_mem_rdata;
            state          <= S_CHK;
          end
        end

        S_CHK: begin
          if (!i_dec_err) begin
            state <= S_NXT;
          end else if (i_dec_dbl) begin
            if (o_ue_count != CNT_MAX) o_ue_count <= o_ue_count + 16'd1;
`ifdef ECC_SCRUB_ERRLOG_EN
            o_last_ue_addr <= o_mem_addr;
`endif
            state <= S_NXT;
          end else begin
            if (o_ce_count != CNT_MAX) o_ce_count <= o_ce_count + 16'd1;
`ifdef ECC_SCRUB_ERRLOG_EN
            o_last_ce_addr <= o_mem_addr;
`endif
            o_enc_data <= i_dec_data;
            state      <= S_ENC;
          end
        end

        S_ENC: begin
          o_mem_wdata <= i_enc_codeword;
          o_mem_req   <= 1'b1;
          o_mem_we    <= 1'b1;
          state       <= S_WR;
        end

        S_WR: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            state     <= S_NXT;
          end
        end

        S_NXT: begin
          if (o_mem_addr == ALAST) begin
            o_mem_addr  <= '0;
            o_pass_done <= 1'b1;
          end else begin
            o_mem_addr <= o_mem_addr + 1'b1;
          end
          o_busy <= 1'b0;
          state  <= i_enable ? S_WAIT : S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataint_ecc_scrub_ctrl.sv
// Scoreboard bench for dataint_ecc_scrub_ctrl: RAM/arbiter model with a toy two-flag ECC code.
module tb_dataint_ecc_scrub_ctrl;
  localparam int WIDTH    = 32;
  localparam int AW       = 10;
  localparam int DEPTH    = 4;
  localparam int INTERVAL = 2;
  localparam int CW       = WIDTH + $clog2(WIDTH + $clog2(WIDTH) + 1) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              mem_req;
  logic              mem_gnt = 1'b1;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [CW-1:0]     mem_wdata;
  logic              mem_rvalid = 1'b0;
  logic [CW-1:0]     mem_rdata = '0;
  logic [CW-1:0]     dec_cw;
  logic [WIDTH-1:0]  dec_data;
  logic              dec_err;
  logic              dec_dbl;
  logic [WIDTH-1:0]  enc_data;
  logic [CW-1:0]     enc_cw;
  logic              busy;
  logic              pass_done;
  logic [15:0]       ce_count;
  logic [15:0]       ue_count;
`ifdef ECC_SCRUB_ERRLOG_EN
  logic [AW-1:0]     last_ce_addr;
  logic [AW-1:0]     last_ue_addr;
`endif

  dataint_ecc_scrub_ctrl #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INTERVAL(INTERVAL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_dec_codeword(dec_cw), .i_dec_data(dec_data), .i_dec_err(dec_err), .i_dec_dbl(dec_dbl),
    .o_enc_data(enc_data), .i_enc_codeword(enc_cw),
    .o_busy(busy), .o_pass_done(pass_done), .o_ce_count(ce_count), .o_ue_count(ue_count)
`ifdef ECC_SCRUB_ERRLOG_EN
    , .o_last_ce_addr(last_ce_addr), .o_last_ue_addr(last_ue_addr)
`endif
  );

  initial forever #5 clk = ~clk;

  // Toy code: [38:37] error flags (01 single, 10 double), [36:32] check bits, [31:0] data.
  function automatic logic [CW-1:0] enc(input logic [WIDTH-1:0] d);
    return {2'b00, d[4:0] ^ 5'h15, d};
  endfunction
  function automatic logic [CW-1:0] bad1(input logic [WIDTH-1:0] d);
    return {2'b01, d[4:0] ^ 5'h15, d ^ 32'h1};
  endfunction
  function automatic logic [CW-1:0] bad2(input logic [WIDTH-1:0] d);
    return {2'b10, d[4:0] ^ 5'h15, d ^ 32'h3};
  endfunction

  assign dec_err  = dec_cw[CW-1] | dec_cw[CW-2];
  assign dec_dbl  = dec_cw[CW-1];
  assign dec_data = dec_cw[CW-2] ? (dec_cw[WIDTH-1:0] ^ 32'h1) : dec_cw[WIDTH-1:0];
  assign enc_cw   = enc(enc_data);

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
  } xfer_t;

  xfer_t            exp_q[$];
  logic [CW-1:0]    mem[DEPTH];
  logic [WIDTH-1:0] dval[DEPTH];
  int               n_vec = 0;
  int               n_err = 0;
  int               hold_rd = 0;
  int               hold_wr = 0;
  int               pass_cnt = 0;
  int               exp_pass = 0;
  logic [15:0]      exp_ce = 16'd0;
  logic [15:0]      exp_ue = 16'd0;
  bit               stalling = 1'b0;
  bit               rd_pend = 1'b0;
  logic [CW-1:0]    rd_buf = '0;
  logic             snap_we;
  logic [AW-1:0]    snap_addr;
  logic [CW-1:0]    snap_wdata;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int a);
    exp_q.push_back('{we: 1'b0, addr: AW'(a), wdata: '0});
  endtask
  task automatic push_wr(input int a, input logic [CW-1:0] wd);
    exp_q.push_back('{we: 1'b1, addr: AW'(a), wdata: wd});
  endtask

  // RAM + arbiter model: decides gnt each negedge, scoreboards every transfer.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      rd_pend    = 1'b0;
      stalling   = 1'b0;
    end else begin
      mem_rvalid = rd_pend;
      if (rd_pend) mem_rdata = rd_buf;
      rd_pend = 1'b0;
      if (pass_done) pass_cnt++;
      if (stalling) begin
        check_eq("stall_req", mem_req, 1'b1);
        check_eq("stall_we", mem_we, snap_we);
        check_eq("stall_addr", mem_addr, snap_addr);
        check_eq("stall_wdata", mem_wdata, snap_wdata);
        if (!mem_req) stalling = 1'b0;
      end
      if (mem_req) begin
        if (mem_we ? (hold_wr > 0) : (hold_rd > 0)) begin
          if (!stalling) begin
            snap_we    = mem_we;
            snap_addr  = mem_addr;
            snap_wdata = mem_wdata;
          end
          stalling = 1'b1;
          mem_gnt  = 1'b0;
          if (mem_we) hold_wr--; else hold_rd--;
        end else begin
          xfer_t x;
          mem_gnt  = 1'b1;
          stalling = 1'b0;
          check_eq("xfer_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check_eq("xfer_we", mem_we, x.we);
            check_eq("xfer_addr", mem_addr, x.addr);
            if (x.we) check_eq("xfer_wdata", mem_wdata, x.wdata);
          end
          if (mem_we) mem[mem_addr[1:0]] = mem_wdata;
          else begin
            rd_buf  = mem[mem_addr[1:0]];
            rd_pend = 1'b1;
          end
        end
      end else begin
        mem_gnt = 1'b1;
      end
    end
  end

  task automatic run_pass(input int bound);
    int n;
    n = 0;
    enable = 1'b1;
    @(negedge clk);
    while (!pass_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("pass_done", pass_done, 1'b1);
    check_eq("q_drained", exp_q.size(), 0);
    enable = 1'b0;
    exp_pass++;
    repeat (4) @(negedge clk);
    check_eq("pass_cnt", pass_cnt, exp_pass);
    check_eq("ce_count", ce_count, exp_ce);
    check_eq("ue_count", ue_count, exp_ue);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  task automatic push_pass(input int wa, input logic [CW-1:0] wd);
    for (int a = 0; a < DEPTH; a++) begin
      push_rd(a);
      if (a == wa) push_wr(a, wd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      dval[a] = $urandom();
      mem[a]  = enc(dval[a]);
    end
    repeat (3) @(negedge clk);
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_addr", mem_addr, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pass", pass_done, 1'b0);
    check_eq("rst_ce", ce_count, '0);
    check_eq("rst_wdata", mem_wdata, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean pass: four reads, no writes.
    push_pass(-1, '0);
    run_pass(300);
    check_eq("clean_addr_wrap", mem_addr, '0);

    // Single-bit error at addr 2.
    mem[2] = bad1(dval[2]);
    push_pass(2, enc(dval[2]));
    exp_ce = 16'd1;
    run_pass(300);
    check_eq("mem2_fixed", mem[2], enc(dval[2]));
`ifdef ECC_SCRUB_ERRLOG_EN
    check_eq("last_ce_addr", last_ce_addr, 10'd2);
`endif

    // Double error at addr 1: counted, not written back.
    mem[1] = bad2(dval[1]);
    push_pass(-1, '0);
    exp_ue = 16'd1;
    run_pass(300);
`ifdef ECC_SCRUB_ERRLOG_EN
    check_eq("last_ue_addr", last_ue_addr, 10'd1);
`endif

    // Grant withheld for 5 cycles on both read and write-back.
    mem[1] = enc(dval[1]);
    dval[0] = $urandom();
    mem[0] = bad1(dval[0]);
    hold_rd = 5;
    hold_wr = 5;
    push_pass(0, enc(dval[0]));
    exp_ce = 16'd2;
    run_pass(400);

    // Enable dropped during RDW of addr 1: step completes, FSM parks.
    dval[1] = $urandom();
    mem[1] = bad1(dval[1]);
    push_rd(0);
    push_rd(1);
    push_wr(1, enc(dval[1]));
    exp_ce = 16'd3;
    enable = 1'b1;
    n = 0;
    while (!(busy && !mem_req && mem_addr == 10'd1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("rdw_reached", busy && !mem_req && mem_addr == 10'd1, 1'b1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_eq("drop_busy", busy, 1'b0);
    check_eq("drop_q", exp_q.size(), 0);
    check_eq("drop_addr", mem_addr, 10'd2);
    check_eq("drop_ce", ce_count, exp_ce);
`ifdef ECC_SCRUB_ERRLOG_EN
    check_eq("drop_last_ce", last_ce_addr, 10'd1);
`endif
    push_rd(2);
    push_rd(3);
    run_pass(300);

    // Saturation: preload near the top, two more corrections.
    force dut.o_ce_count = 16'hFFFE;
    @(negedge clk);
    release dut.o_ce_count;
    dval[0] = $urandom();
    dval[1] = $urandom();
    mem[0] = bad1(dval[0]);
    mem[1] = bad1(dval[1]);
    push_rd(0); push_wr(0, enc(dval[0]));
    push_rd(1); push_wr(1, enc(dval[1]));
    push_rd(2); push_rd(3);
    exp_ce = 16'hFFFF;
    run_pass(400);

    // Async reset while the write-back waits for grant.
    dval[1] = $urandom();
    mem[1] = bad1(dval[1]);
    hold_wr = 50;
    push_rd(0); push_rd(1);
    enable = 1'b1;
    n = 0;
    while (!(mem_req && mem_we) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_reached", mem_req && mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", mem_req, 1'b0);
    check_eq("arst_we", mem_we, 1'b0);
    check_eq("arst_addr", mem_addr, '0);
    check_eq("arst_wdata", mem_wdata, '0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_ce", ce_count, '0);
    check_eq("arst_ue", ue_count, '0);
    check_eq("arst_deccw", dec_cw, '0);
    check_eq("arst_encd", enc_data, '0);
    enable = 1'b0;
    hold_wr = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Restart from addr 0; the uncorrected word at addr 1 gets fixed now.
    push_pass(1, enc(dval[1]));
    exp_ce = 16'd1;
    exp_ue = 16'd0;
    run_pass(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
